icache_direct: RTL

Read-only, direct-mapped instruction cache between the pipeline's instruction-fetch port (word-addressed, stall-based) and the off-chip instruction memory (128-bit block interface). Hits return the instruction combinationally in the request cycle with no stall. Misses hold `proc_stall` high while a 4-word block is fetched, then replay as a hit. Writes from the fetch side are never performed.

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_direct_if.sv | 36 +++
 rtl/icache_line_array.sv | 47 ++++
 rtl/icache_direct.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   localparam int BLOCK_W    = 128;
   localparam int WORD_W     = 32;
   localparam int ADDR_W     = 30;
   localparam int MEM_ADDR_W = 28;

   function automatic int tag_width(input int lines);
      return MEM_ADDR_W - $clog2(lines);
   endfunction

   // Pick one 32-bit instruction out of a 128-bit block; word 0 sits in the low bits.
   function automatic logic [WORD_W-1:0] word_select(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         off);
      logic [WORD_W-1:0] w;
      case (off)
         2'd0:    w = blk[31:0];
         2'd1:    w = blk[63:32];
         2'd2:    w = blk[95:64];
         2'd3:    w = blk[127:96];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side buses of the instruction cache.
interface icache_proc_if;
   logic                            proc_read;
   logic                            proc_write;
   logic [icache_pkg::ADDR_W-1:0]   proc_addr;
   logic [icache_pkg::WORD_W-1:0]   proc_wdata;
   logic [icache_pkg::WORD_W-1:0]   proc_rdata;
   logic                            proc_stall;

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata,
      input  proc_rdata, proc_stall
   );
   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata,
      output proc_rdata, proc_stall
   );
endinterface

interface icache_mem_if;
   logic                              mem_read;
   logic                              mem_write;
   logic [icache_pkg::MEM_ADDR_W-1:0] mem_addr;
   logic [icache_pkg::BLOCK_W-1:0]    mem_wdata;
   logic [icache_pkg::BLOCK_W-1:0]    mem_rdata;
   logic                              mem_ready;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );
   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int LINES = 8,
   parameter int TAG_W = 25
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(LINES)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [TAG_W-1:0]         rd_tag,
   output logic [BLOCK_W-1:0]       rd_data,
   input  logic                     wr_en,
   input  logic [$clog2(LINES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]         wr_tag,
   input  logic [BLOCK_W-1:0]       wr_data
);

   logic [LINES-1:0]   valid_r;
   logic [TAG_W-1:0]   tag_r  [LINES];
   logic [BLOCK_W-1:0] data_r [LINES];

   // Valid bits: cleared by reset, which also overrides a same-cycle fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else if (wr_en) begin
         valid_r[wr_idx] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Tag and data contents carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[wr_idx]  <= wr_tag;
         data_r[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_r[rd_idx];
   assign rd_tag   = tag_r[rd_idx];
   assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Read-only direct-mapped I-cache; define ICACHE_PERF_EN to build hit/miss counters.
module icache_direct
   import icache_pkg::*;
#(
   parameter int LINES = 8
) (
   input  logic         clk,
   input  logic         proc_reset,
   icache_proc_if.slave proc,
   icache_mem_if.master mem,
   output logic [31:0]  perf_hits,
   output logic [31:0]  perf_misses
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = tag_width(LINES);

   state_t                  state_r;
   logic [MEM_ADDR_W-1:0]   miss_addr_r;
   logic                    mem_read_r;

   logic [IDX_W-1:0]        idx_s;
   logic [TAG_W-1:0]        tag_s;
   logic [1:0]              off_s;
   logic                    line_valid_s;
   logic [TAG_W-1:0]        line_tag_s;
   logic [BLOCK_W-1:0]      line_data_s;
   logic                    hit_s;
   logic                    miss_s;
   logic                    fill_s;
   logic                    unused_s;

   assign off_s = proc.proc_addr[1:0];
   assign idx_s = proc.proc_addr[IDX_W+1:2];
   assign tag_s = proc.proc_addr[ADDR_W-1:IDX_W+2];

   icache_line_array #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_lines (
      .clk      (clk),
      .rst      (proc_reset),
      .rd_idx   (idx_s),
      .rd_valid (line_valid_s),
      .rd_tag   (line_tag_s),
      .rd_data  (line_data_s),
      .wr_en    (fill_s),
      .wr_idx   (miss_addr_r[IDX_W-1:0]),
      .wr_tag   (miss_addr_r[MEM_ADDR_W-1:IDX_W]),
      .wr_data  (mem.mem_rdata)
   );

   // Hit/miss decode; only meaningful while idle.
   always_comb begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
      if (state_r == IDLE && proc.proc_read) begin
         hit_s  = line_valid_s && (line_tag_s == tag_s);
         miss_s = !hit_s;
      end else begin
         hit_s  = 1'b0;
         miss_s = 1'b0;
      end
   end

   assign fill_s = (state_r == FETCH) && mem.mem_ready;

   // Controller: latch the missing block address and hold mem_read until the block arrives.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_r     <= IDLE;
         miss_addr_r <= '0;
         mem_read_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_s) begin
                  state_r     <= FETCH;
                  miss_addr_r <= proc.proc_addr[ADDR_W-1:2];
                  mem_read_r  <= 1'b1;
               end
            end
            FETCH: begin
               if (mem.mem_ready) begin
                  state_r    <= IDLE;
                  mem_read_r <= 1'b0;
               end
            end
            default: begin
               state_r    <= IDLE;
               mem_read_r <= 1'b0;
            end
         endcase
      end
   end

   // Fetch-side response: stall on a detected miss and throughout the fetch.
   always_comb begin
      proc.proc_rdata = word_select(line_data_s, off_s);
      if (state_r == FETCH) begin
         proc.proc_stall = 1'b1;
      end else begin
         proc.proc_stall = miss_s;
      end
   end

   // While idle the address bus follows the core so it shows the block about to be requested.
   always_comb begin
      if (state_r == FETCH) begin
         mem.mem_addr = miss_addr_r;
      end else begin
         mem.mem_addr = proc.proc_addr[ADDR_W-1:2];
      end
   end

   assign mem.mem_read  = mem_read_r;
   assign mem.mem_write = 1'b0;
   assign mem.mem_wdata = {BLOCK_W{1'b0}};

   // The fetch side is read-only; write requests and data are deliberately dropped.
   assign unused_s = &{1'b0, proc.proc_write, proc.proc_wdata};

`ifdef ICACHE_PERF_EN
   logic [31:0] perf_hits_r;
   logic [31:0] perf_misses_r;

   // Event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         perf_hits_r   <= 32'd0;
         perf_misses_r <= 32'd0;
      end else begin
         if (hit_s) begin
            perf_hits_r <= perf_hits_r + 32'd1;
         end
         if (miss_s) begin
            perf_misses_r <= perf_misses_r + 32'd1;
         end
      end
   end

   assign perf_hits   = perf_hits_r;
   assign perf_misses = perf_misses_r;
`else
   assign perf_hits   = 32'd0;
   assign perf_misses = 32'd0;
`endif

endmodule
